// File: rtl/pq_sorted_queue.sv
// rtl/pq_sorted_queue.sv - register-based sorted priority queue (optional PQ_EVICT_EN eviction on full push)
module pq_sorted_queue #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int MIN_FIRST = 1,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              push_ready_o,
  input  logic              pop_i,
  output logic [DATA_W-1:0] top_o,
  output logic              top_valid_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_o,
  output logic [DATA_W-1:0] evict_data_o,
  output logic              evict_valid_o
);

  localparam logic [DATA_W-1:0] SENT     = (MIN_FIRST != 0) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] slot_q [DEPTH];
  logic [DATA_W-1:0] slot_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              top_valid_q, top_valid_d;
  logic              err_q, err_d;
  logic              evict_valid_q, evict_valid_d;
  logic [DATA_W-1:0] evict_data_q, evict_data_d;

  logic [DATA_W-1:0] base [DEPTH];
  logic [DATA_W-1:0] ins [DEPTH];
  logic [CNT_W-1:0]  base_cnt;
  logic [CNT_W-1:0]  ins_pos;
  logic              do_pop;
  logic              is_full;

  // Strict priority test: a is served before b (equal keys never beat, giving FIFO ties)
  function automatic logic beats(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (MIN_FIRST != 0) return a < b;
    else return a > b;
  endfunction

  // Array as it looks after an accepted pop (top removed, sentinel shifted in at the tail)
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    is_full  = (count_q == FULL_CNT);
    base_cnt = do_pop ? count_q - CNT_W'(1) : count_q;
    for (int i = 0; i < DEPTH - 1; i++) begin
      base[i] = do_pop ? slot_q[i+1] : slot_q[i];
    end
    base[DEPTH-1] = do_pop ? SENT : slot_q[DEPTH-1];
  end

  // Insert position = number of valid entries the new key does not beat; tail entry drops off
  always_comb begin
    ins_pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < base_cnt) && !beats(push_data_i, base[i])) begin
        ins_pos = ins_pos + CNT_W'(1);
      end
    end
    ins[0] = (ins_pos == '0) ? push_data_i : base[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (CNT_W'(i) < ins_pos)       ins[i] = base[i];
      else if (CNT_W'(i) == ins_pos) ins[i] = push_data_i;
      else                           ins[i] = base[i-1];
    end
  end

  // Next-state selection: clear, insert/replace, full-push handling, plain pop
  always_comb begin
    slot_d        = slot_q;
    count_d       = count_q;
    err_d         = 1'b0;
    evict_valid_d = 1'b0;
    evict_data_d  = '0;
    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) slot_d[i] = SENT;
      count_d = '0;
    end else begin
      if (pop_i && !do_pop) err_d = 1'b1;
      if (push_i && (!is_full || do_pop)) begin
        slot_d  = ins;
        count_d = base_cnt + CNT_W'(1);
      end else if (push_i) begin
`ifdef PQ_EVICT_EN
        evict_valid_d = 1'b1;
        if (beats(push_data_i, slot_q[DEPTH-1])) begin
          slot_d       = ins;
          evict_data_d = slot_q[DEPTH-1];
        end else begin
          evict_data_d = push_data_i;
        end
`else
        err_d = 1'b1;
`endif
      end else if (do_pop) begin
        slot_d  = base;
        count_d = base_cnt;
      end
    end
    full_d      = (count_d == FULL_CNT);
    empty_d     = (count_d == '0);
    top_valid_d = (count_d != '0);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= SENT;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      top_valid_q   <= 1'b0;
      err_q         <= 1'b0;
      evict_valid_q <= 1'b0;
      evict_data_q  <= '0;
    end else begin
      slot_q        <= slot_d;
      count_q       <= count_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      top_valid_q   <= top_valid_d;
      err_q         <= err_d;
      evict_valid_q <= evict_valid_d;
      evict_data_q  <= evict_data_d;
    end
  end

`ifdef PQ_EVICT_EN
  assign push_ready_o = 1'b1;
`else
  assign push_ready_o = !full_q || pop_i;
`endif
  assign top_o         = slot_q[0];
  assign top_valid_o   = top_valid_q;
  assign count_o       = count_q;
  assign full_o        = full_q;
  assign empty_o       = empty_q;
  assign err_o         = err_q;
  assign evict_valid_o = evict_valid_q;
  assign evict_data_o  = evict_data_q;

endmodule

// File: tb/tb_pq_sorted_queue.sv
// tb/tb_pq_sorted_queue.sv - self-checking bench for pq_sorted_queue against a sorted-list model
module tb_pq_sorted_queue;
  localparam int DW = 32;
  localparam int D  = 4;
  localparam int CW = 3;
  localparam logic [31:0] SENT = 32'hFFFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clear_i, push_i, pop_i;
  logic [DW-1:0] push_data_i;
  logic          push_ready_o, top_valid_o, full_o, empty_o, err_o, evict_valid_o;
  logic [DW-1:0] top_o, evict_data_o;
  logic [CW-1:0] count_o;

  logic          b_clear, b_push, b_pop;
  logic [DW-1:0] b_data;
  logic          b_ready, b_tv, b_full, b_empty, b_err, b_evv;
  logic [DW-1:0] b_top, b_evd;
  logic [CW-1:0] b_cnt;

  pq_sorted_queue #(.DATA_W(DW), .DEPTH(D), .MIN_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .push_i(push_i), .push_data_i(push_data_i),
    .push_ready_o(push_ready_o), .pop_i(pop_i), .top_o(top_o), .top_valid_o(top_valid_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .err_o(err_o),
    .evict_data_o(evict_data_o), .evict_valid_o(evict_valid_o)
  );

  pq_sorted_queue #(.DATA_W(DW), .DEPTH(D), .MIN_FIRST(0)) dut_max (
    .clk(clk), .rst_n(rst_n), .clear_i(b_clear), .push_i(b_push), .push_data_i(b_data),
    .push_ready_o(b_ready), .pop_i(b_pop), .top_o(b_top), .top_valid_o(b_tv),
    .count_o(b_cnt), .full_o(b_full), .empty_o(b_empty), .err_o(b_err),
    .evict_data_o(b_evd), .evict_valid_o(b_evv)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] mq[$];
  logic        e_err, e_evv;
  logic [31:0] e_evd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_insert(input logic [31:0] k);
    int idx = mq.size();
    for (int i = 0; i < mq.size(); i++) begin
      if (k < mq[i]) begin idx = i; break; end
    end
    mq.insert(idx, k);
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".top"}, top_o, (mq.size() > 0) ? mq[0] : SENT);
    chk({tag, ".top_valid"}, {31'b0, top_valid_o}, {31'b0, mq.size() > 0});
    chk({tag, ".count"}, {29'b0, count_o}, mq.size());
    chk({tag, ".full"}, {31'b0, full_o}, {31'b0, mq.size() == D});
    chk({tag, ".empty"}, {31'b0, empty_o}, {31'b0, mq.size() == 0});
  endtask

  // One clocked operation: drive, check push_ready, update model, clock, check everything
  task automatic op(input string tag, input bit c, input bit pu, input logic [31:0] d, input bit po);
    logic exp_ready;
    clear_i = c; push_i = pu; push_data_i = d; pop_i = po;
    #1;
`ifdef PQ_EVICT_EN
    exp_ready = 1'b1;
`else
    exp_ready = (mq.size() < D) || po;
`endif
    chk({tag, ".push_ready"}, {31'b0, push_ready_o}, {31'b0, exp_ready});
    e_err = 1'b0; e_evv = 1'b0; e_evd = '0;
    if (c) begin
      mq.delete();
    end else begin
      if (po && mq.size() == 0) e_err = 1'b1;
      if (pu && po && mq.size() > 0) begin
        void'(mq.pop_front());
        model_insert(d);
      end else if (pu) begin
        if (mq.size() < D) model_insert(d);
        else begin
`ifdef PQ_EVICT_EN
          e_evv = 1'b1;
          if (d < mq[D-1]) begin
            e_evd = mq[D-1];
            void'(mq.pop_back());
            model_insert(d);
          end else e_evd = d;
`else
          e_err = 1'b1;
`endif
        end
      end else if (po && mq.size() > 0) begin
        void'(mq.pop_front());
      end
    end
    @(posedge clk);
    #1;
    clear_i = 0; push_i = 0; pop_i = 0;
    check_state(tag);
    chk({tag, ".err"}, {31'b0, err_o}, {31'b0, e_err});
    chk({tag, ".evict_valid"}, {31'b0, evict_valid_o}, {31'b0, e_evv});
    chk({tag, ".evict_data"}, evict_data_o, e_evd);
  endtask

  task automatic load4(input string tag);
    op({tag, ".clr"}, 1, 0, 0, 0);
    op({tag, ".p9"}, 0, 1, 9, 0);
    op({tag, ".p4"}, 0, 1, 4, 0);
    op({tag, ".p6"}, 0, 1, 6, 0);
    op({tag, ".p1"}, 0, 1, 1, 0);
  endtask

  task automatic drain4(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2, input logic [31:0] e3);
    chk({tag, ".d0"}, top_o, e0); op({tag, ".pop0"}, 0, 0, 0, 1);
    chk({tag, ".d1"}, top_o, e1); op({tag, ".pop1"}, 0, 0, 0, 1);
    chk({tag, ".d2"}, top_o, e2); op({tag, ".pop2"}, 0, 0, 0, 1);
    chk({tag, ".d3"}, top_o, e3); op({tag, ".pop3"}, 0, 0, 0, 1);
  endtask

  initial begin
    rst_n = 0; clear_i = 0; push_i = 0; pop_i = 0; push_data_i = 0;
    b_clear = 0; b_push = 0; b_pop = 0; b_data = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    #1;
    check_state("reset");
    chk("reset.err", {31'b0, err_o}, 0);
    chk("reset.evict_valid", {31'b0, evict_valid_o}, 0);
    chk("reset.evict_data", evict_data_o, 0);

    op("p2", 0, 1, 2, 0);
    op("p1", 0, 1, 1, 0);
    chk("two.top", top_o, 1);
    chk("two.count", {29'b0, count_o}, 2);

    load4("full");
    chk("full.flag", {31'b0, full_o}, 1);
    chk("full.top", top_o, 1);
`ifdef PQ_EVICT_EN
    op("ev8", 0, 1, 8, 0);
    chk("ev8.data", evict_data_o, 9);
    op("ev10", 0, 1, 10, 0);
    chk("ev10.data", evict_data_o, 10);
    op("ev_idle", 0, 0, 0, 0);
    drain4("evdrain", 1, 4, 6, 8);
`else
    push_i = 1; push_data_i = 8; #1;
    chk("rej.ready", {31'b0, push_ready_o}, 0);
    op("rej8", 0, 1, 8, 0);
    chk("rej.err", {31'b0, err_o}, 1);
    op("rej_idle", 0, 0, 0, 0);
    chk("rej.err_once", {31'b0, err_o}, 0);
    drain4("rejdrain", 1, 4, 6, 9);
`endif

    load4("repl");
    op("repl5", 0, 1, 5, 1);
    chk("repl.top", top_o, 4);
    chk("repl.count", {29'b0, count_o}, 4);
    drain4("repldrain", 4, 5, 6, 9);

    load4("pops");
    drain4("popdrain", 1, 4, 6, 9);
    chk("pops.top_sent", top_o, SENT);
    op("pop_empty", 0, 0, 0, 1);
    chk("pop_empty.err", {31'b0, err_o}, 1);
    op("pushpop_empty", 0, 1, 7, 1);
    chk("pushpop_empty.top", top_o, 7);

    // Randomized ops with ties and sentinel-valued keys
    for (int n = 0; n < 400; n++) begin
      logic [31:0] k;
      int r = $urandom_range(0, 99);
      k = ($urandom_range(0, 5) == 0) ? SENT : 32'($urandom_range(0, 12));
      op("rand", r < 3, $urandom_range(0, 2) != 0, k, $urandom_range(0, 2) == 0);
    end

    // Largest-first instance
    @(negedge clk); b_push = 1; b_data = 32'hf657c062;
    @(negedge clk); b_data = 32'hf680d628;
    @(negedge clk); b_push = 0;
    chk("max.top1", b_top, 32'hf680d628);
    chk("max.cnt", {29'b0, b_cnt}, 2);
    b_pop = 1;
    @(negedge clk); b_pop = 0;
    chk("max.top2", b_top, 32'hf657c062);

    // Asynchronous reset while a push is pending at count 3
    op("ar.clr", 1, 0, 0, 0);
    op("ar.a", 0, 1, 3, 0);
    op("ar.b", 0, 1, 8, 0);
    op("ar.c", 0, 1, 5, 0);
    push_i = 1; push_data_i = 2;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    mq.delete();
    check_state("async");
    chk("async.err", {31'b0, err_o}, 0);
    chk("async.evict_valid", {31'b0, evict_valid_o}, 0);
    chk("max.async_top", b_top, 0);
    @(posedge clk); #1;
    push_i = 0;
    check_state("async_hold");
    #2 rst_n = 1;
    op("after_ar", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
